// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: variable-latency imem read, decode hold, redirect flush
module ifetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pc_adv,
    input  logic              i_flush,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid,
    output logic              o_instr_err,
    input  logic              i_instr_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              err_q, err_d;
    logic              take_pc;
    logic              pc_misaligned;

    assign pc_misaligned = |i_pc[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        err_d    = err_q;
        o_pc_adv = 1'b0;
        take_pc  = 1'b0;
        case (state_q)
            S_IDLE: take_pc = 1'b1;
            S_REQ: begin
                if (i_imem_ack) begin
                    if (i_flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_FULL;
                        instr_d  = i_imem_rdata;
                        pc_d     = addr_q;
                        err_d    = 1'b0;
                        o_pc_adv = 1'b1;
                    end
                end else if (i_flush) begin
                    state_d = S_DROP;
                end
            end
            // The memory cannot cancel a read, so wait out the ack and throw it away.
            S_DROP: begin
                if (i_imem_ack) state_d = S_IDLE;
            end
            S_FULL: begin
                if (i_flush) state_d = S_IDLE;
                else if (i_instr_ready) take_pc = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A misaligned PC never reaches memory; it is handed to decode as a faulting NOP.
        if (take_pc) begin
            addr_d = i_pc;
            if (pc_misaligned) begin
                state_d = S_FULL;
                instr_d = NOP_INSTR;
                pc_d    = i_pc;
                err_d   = 1'b1;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    assign o_imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
    assign o_imem_addr   = addr_q;
    assign o_instr_valid = (state_q == S_FULL);
    assign o_instr       = o_instr_valid ? instr_q : NOP_INSTR;
    assign o_instr_pc    = pc_q;
    assign o_instr_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with PC model, memory model and scoreboard
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcv;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        pc_adv, imem_req, instr_valid, instr_err;
    logic [31:0] imem_addr, instr, instr_pc;

    ifetch_unit dut (
        .i_clk(clk), .i_rst(rst), .i_pc(pcv), .o_pc_adv(pc_adv), .i_flush(flush),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_instr(instr), .o_instr_pc(instr_pc), .o_instr_valid(instr_valid),
        .o_instr_err(instr_err), .i_instr_ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          vcyc[$];
    int          advcyc[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          adv_cnt = 0;
    int          nseen = 0;
    int          lat = 1;
    int          mcnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] fl_target = '0;
    logic        pv = 1'b0, pacc = 1'b0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'h0050_0093 + {a[23:0], 8'h00};
    endfunction

    // Memory: acks exactly lat cycles after the request rises, never cancels.
    always @(posedge clk) begin
        #1;
        if (imem_req) mcnt = mcnt + 1;
        else mcnt = 0;
        if (force_ack || (imem_req && mcnt == lat + 1)) begin
            ack   = 1'b1;
            rdata = mem_word(imem_addr);
        end else begin
            ack   = 1'b0;
            rdata = 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic e);
        exp_t x;
        x.instr = i;
        x.pc    = p;
        x.err   = e;
        sbq.push_back(x);
    endtask

    // One clock: monitor at negedge, then PC register model after the rising edge.
    task automatic tick();
        logic adv_s, fl_s;
        exp_t e;
        @(negedge clk);
        if (instr_valid && (!pv || pacc)) begin
            nseen++;
            vcyc.push_back(cyc);
            if (sbq.size() == 0) begin
                check("unexpected_valid", {31'b0, instr_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("instr", instr, e.instr);
                check("instr_pc", instr_pc, e.pc);
                check("instr_err", {31'b0, instr_err}, {31'b0, e.err});
            end
        end
        pv   = instr_valid;
        pacc = instr_valid && ready && !flush;
        if (pc_adv) begin
            adv_cnt++;
            advcyc.push_back(cyc);
        end
        adv_s = pc_adv;
        fl_s  = flush;
        @(posedge clk);
        cyc++;
        #2;
        if (fl_s) pcv = fl_target;
        else if (adv_s) pcv = pcv + 32'd4;
    endtask

    task automatic reset_dut(input logic [31:0] start_pc);
        rst   = 1'b1;
        flush = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        pcv = start_pc;
        rst = 1'b0;
        t0  = cyc;
        vcyc.delete();
        advcyc.delete();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !instr_valid; i++) tick();
        check({tag, "_timeout"}, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_adv"}, {31'b0, pc_adv}, 32'd0);
        check({tag, "_instr"}, instr, NOP);
        check({tag, "_ipc"}, instr_pc, 32'd0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_err"}, {31'b0, instr_err}, 32'd0);
    endtask

    initial begin
        int   base;
        logic saw_req;
        rst = 1'b1; flush = 1'b0; ready = 1'b0; pcv = '0;
        tick();
        tick();
        check_reset_outputs("rst");

        // Single fetch at L=1, then decode stalls for 5 cycles.
        lat  = 1;
        base = adv_cnt;
        reset_dut(32'h0);
        push_exp(32'h0050_0093, 32'h0, 1'b0);
        wait_valid("t1");
        tick();
        check("t1_valid_cycle", vcyc[0] - t0, 32'd3);
        check("t1_adv_cycle", advcyc[0] - t0, 32'd2);
        check("t1_adv_count", adv_cnt - base, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'b0, instr_valid}, 32'd1);
            check("hold_instr", instr, 32'h0050_0093);
            check("hold_pc", instr_pc, 32'h0);
            check("hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        check("hold_adv_count", adv_cnt - base, 32'd1);

        // Back-to-back with ready high, L=3.
        lat = 3;
        reset_dut(32'h0);
        base  = adv_cnt;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) push_exp(mem_word(32'(i * 4)), 32'(i * 4), 1'b0);
        for (int i = 0; i < 100 && !(adv_cnt - base == 3 && instr_valid); i++) tick();
        ready = 1'b0;
        tick();
        check("b2b_seen", vcyc.size(), 32'd3);
        check("b2b_gap0", vcyc[1] - vcyc[0], 32'd5);
        check("b2b_gap1", vcyc[2] - vcyc[1], 32'd5);
        for (int i = 0; i < 6; i++) tick();
        check("b2b_adv_count", adv_cnt - base, 32'd3);
        check("b2b_idle_noreq", {31'b0, imem_req}, 32'd0);

        // Flush one cycle after the request, L=4: stale word must be dropped.
        lat = 4;
        reset_dut(32'h0);
        base = adv_cnt;
        tick();
        check("drop_req_up", {31'b0, imem_req}, 32'd1);
        tick();
        flush = 1'b1; fl_target = 32'h100;
        tick();
        flush = 1'b0;
        check("drop_req_held", {31'b0, imem_req}, 32'd1);
        check("drop_addr_held", imem_addr, 32'h0);
        for (int i = 0; i < 20 && imem_req; i++) tick();
        check("drop_req_done", {31'b0, imem_req}, 32'd0);
        check("drop_no_valid", {31'b0, instr_valid}, 32'd0);
        check("drop_no_adv", adv_cnt - base, 32'd0);
        push_exp(mem_word(32'h100), 32'h100, 1'b0);
        tick();
        check("drop_new_req", {31'b0, imem_req}, 32'd1);
        check("drop_new_addr", imem_addr, 32'h100);
        wait_valid("drop");
        tick();
        check("drop_adv_count", adv_cnt - base, 32'd1);

        // Flush coincident with ack.
        lat = 2;
        reset_dut(32'h0);
        base = adv_cnt;
        for (int i = 0; i < 20 && !ack; i++) tick();
        check("coinc_ack_timeout", {31'b0, ack}, 32'd1);
        flush = 1'b1; fl_target = 32'h200;
        tick();
        flush = 1'b0;
        check("coinc_no_valid", {31'b0, instr_valid}, 32'd0);
        check("coinc_no_adv", adv_cnt - base, 32'd0);
        push_exp(mem_word(32'h200), 32'h200, 1'b0);
        tick();
        check("coinc_req", {31'b0, imem_req}, 32'd1);
        check("coinc_addr", imem_addr, 32'h200);
        wait_valid("coinc");
        tick();
        check("coinc_adv_count", adv_cnt - base, 32'd1);

        // Misaligned PC becomes a faulting NOP without touching memory; next good word clears err.
        lat = 1;
        reset_dut(32'h102);
        base = adv_cnt;
        push_exp(NOP, 32'h102, 1'b1);
        saw_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_req = saw_req | imem_req;
        end
        check("mis_noreq", {31'b0, saw_req}, 32'd0);
        check("mis_valid", {31'b0, instr_valid}, 32'd1);
        check("mis_instr", instr, NOP);
        check("mis_no_adv", adv_cnt - base, 32'd0);
        pcv = 32'h104;
        push_exp(mem_word(32'h104), 32'h104, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        wait_valid("mis_next");
        tick();

        // Reset during REQ, then an ack that lands in IDLE.
        lat = 5;
        reset_dut(32'h40);
        base = adv_cnt;
        tick();
        check("rreq_req", {31'b0, imem_req}, 32'd1);
        check("rreq_addr", imem_addr, 32'h40);
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("rreq");
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        rst = 1'b0;
        tick();
        check("late_ack_req", {31'b0, imem_req}, 32'd1);
        check("late_ack_addr", imem_addr, 32'h40);
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("late_ack_adv", adv_cnt - base, 32'd0);
        push_exp(mem_word(32'h40), 32'h40, 1'b0);
        wait_valid("late_ack");
        tick();
        check("late_ack_adv_count", adv_cnt - base, 32'd1);

        check("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
